// File: rtl/gyro_link_responder.sv
// rtl/gyro_link_responder.sv - device-side gyro serial link: MCK-oversampled deserializer, reply serializer
// Everything runs on clk_i; MCK edges are recovered from synchronized pad samples.
module gyro_link_responder #(
    parameter int WD          = 48,
    parameter int SYNC_STAGES = 2,
    parameter int RX_DEPTH    = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          enable_i,
    input  logic          loopback_i,
    input  logic          mck_i,
    input  logic          dsync_i,
    input  logic          dtx_i,
    output logic          drx_o,
    output logic [WD-1:0] rx_tdata_o,
    output logic          rx_tvalid_o,
    input  logic          rx_tready_i,
    input  logic [WD-1:0] tx_tdata_i,
    input  logic          tx_tvalid_i,
    output logic          tx_tready_o,
    output logic [15:0]   frame_err_count_o,
    output logic [15:0]   overflow_count_o,
    output logic [15:0]   underrun_count_o
);
    localparam int            CW       = $clog2(WD);
    localparam int            AW       = $clog2(RX_DEPTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WD - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);

    typedef enum logic [1:0] {TX_IDLE, TX_ARM, TX_SEND} tx_state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [SYNC_STAGES-1:0] mck_sync_q, dsync_sync_q, dtx_sync_q;
    logic                   mck_dly_q;
    logic                   mck_s, dsync_s, dtx_s, rise, fall;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mck_sync_q   <= '0;
            dsync_sync_q <= '0;
            dtx_sync_q   <= '0;
            mck_dly_q    <= 1'b0;
        end else begin
            mck_sync_q   <= {mck_sync_q[SYNC_STAGES-2:0], mck_i};
            dsync_sync_q <= {dsync_sync_q[SYNC_STAGES-2:0], dsync_i};
            dtx_sync_q   <= {dtx_sync_q[SYNC_STAGES-2:0], dtx_i};
            mck_dly_q    <= mck_s;
        end
    end

    assign mck_s   = mck_sync_q[SYNC_STAGES-1];
    assign dsync_s = dsync_sync_q[SYNC_STAGES-1];
    assign dtx_s   = dtx_sync_q[SYNC_STAGES-1];
    assign rise    = mck_s & ~mck_dly_q;
    assign fall    = ~mck_s & mck_dly_q;

    logic [CW-1:0] bit_cnt_q;
    logic [WD-1:0] shift_q;
    logic [WD-1:0] word_in;
    logic          rx_edge, boundary, frame_done, frame_err;

    assign word_in    = {shift_q[WD-2:0], dtx_s};
    assign rx_edge    = enable_i & rise;
    assign boundary   = rx_edge & dsync_s;
    assign frame_done = boundary & (bit_cnt_q == LAST_BIT);
    // Short frame: DSYNC mid-word; long frame: 48th bit arrives without DSYNC.
    assign frame_err  = (boundary & (bit_cnt_q != '0) & (bit_cnt_q != LAST_BIT))
                      | (rx_edge & ~dsync_s & (bit_cnt_q == LAST_BIT));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
        end else if (!enable_i) begin
            bit_cnt_q <= '0;
        end else if (rise) begin
            shift_q <= word_in;
            if (dsync_s || (bit_cnt_q == LAST_BIT)) begin
                bit_cnt_q <= '0;
            end else begin
                bit_cnt_q <= bit_cnt_q + CNT_ONE;
            end
        end
    end

    logic [WD-1:0] fifo_mem_q [RX_DEPTH];
    logic [AW:0]   wr_ptr_q, rd_ptr_q;
    logic          fifo_full, fifo_pop, fifo_push, fifo_drop;

    assign rx_tvalid_o = (wr_ptr_q != rd_ptr_q);
    assign fifo_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign fifo_pop    = rx_tvalid_o & rx_tready_i;
    // A pop in the same cycle frees the slot the new word needs.
    assign fifo_push   = frame_done & (~fifo_full | fifo_pop);
    assign fifo_drop   = frame_done & fifo_full & ~fifo_pop;
    assign rx_tdata_o  = rx_tvalid_o ? fifo_mem_q[rd_ptr_q[AW-1:0]] : '0;

    always_ff @(posedge clk_i) begin
        if (fifo_push) begin
            fifo_mem_q[wr_ptr_q[AW-1:0]] <= word_in;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (fifo_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (fifo_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    tx_state_t     state_q;
    logic [WD-1:0] tx_sr_q;
    logic [CW-1:0] tx_cnt_q;
    logic [WD-1:0] load_word;
    logic          tx_load, underrun;

    assign tx_load     = boundary & (state_q != TX_IDLE);
    assign load_word   = loopback_i ? (frame_done ? word_in : '0)
                                    : (tx_tvalid_i ? tx_tdata_i : '0);
    assign tx_tready_o = tx_load & ~loopback_i & tx_tvalid_i;
    assign underrun    = tx_load & ~loopback_i & ~tx_tvalid_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= TX_IDLE;
            tx_sr_q  <= '0;
            tx_cnt_q <= '0;
            drx_o    <= 1'b0;
        end else if (!enable_i) begin
            state_q <= TX_IDLE;
            drx_o   <= 1'b0;
        end else begin
            case (state_q)
                TX_IDLE: state_q <= TX_ARM;
                TX_ARM: begin
                    if (tx_load) begin
                        tx_sr_q  <= load_word;
                        tx_cnt_q <= LAST_BIT;
                        state_q  <= TX_SEND;
                    end
                end
                TX_SEND: begin
                    // A new frame boundary aborts the word in flight and reloads.
                    if (tx_load) begin
                        tx_sr_q  <= load_word;
                        tx_cnt_q <= LAST_BIT;
                        drx_o    <= 1'b0;
                    end else if (fall) begin
                        drx_o    <= tx_sr_q[WD-1];
                        tx_sr_q  <= {tx_sr_q[WD-2:0], 1'b0};
                        tx_cnt_q <= tx_cnt_q - CNT_ONE;
                        if (tx_cnt_q == '0) state_q <= TX_ARM;
                    end
                end
                default: state_q <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_err_count_o <= '0;
            overflow_count_o  <= '0;
            underrun_count_o  <= '0;
        end else begin
            if (frame_err) frame_err_count_o <= sat_inc(frame_err_count_o);
            if (fifo_drop) overflow_count_o  <= sat_inc(overflow_count_o);
            if (underrun)  underrun_count_o  <= sat_inc(underrun_count_o);
        end
    end
endmodule

// File: tb/tb_gyro_link_responder.sv
// tb/tb_gyro_link_responder.sv - randomized bench for gyro_link_responder with queue-based link model
module tb_gyro_link_responder;
    logic        clk = 1'b0;
    logic        rst_i, enable_i, loopback_i, mck_i, dsync_i, dtx_i;
    logic        drx_o, rx_tvalid_o, rx_tready_i, tx_tvalid_i, tx_tready_o;
    logic [47:0] rx_tdata_o, tx_tdata_i;
    logic [15:0] frame_err_count_o, overflow_count_o, underrun_count_o;

    always #5 clk = ~clk;

    gyro_link_responder dut (
        .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i), .loopback_i(loopback_i),
        .mck_i(mck_i), .dsync_i(dsync_i), .dtx_i(dtx_i), .drx_o(drx_o),
        .rx_tdata_o(rx_tdata_o), .rx_tvalid_o(rx_tvalid_o), .rx_tready_i(rx_tready_i),
        .tx_tdata_i(tx_tdata_i), .tx_tvalid_i(tx_tvalid_i), .tx_tready_o(tx_tready_o),
        .frame_err_count_o(frame_err_count_o), .overflow_count_o(overflow_count_o),
        .underrun_count_o(underrun_count_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state: bits of the frame in progress, expected words, counters, reply word.
    bit          m_frame[$];
    logic [47:0] exp_q[$], got_q[$], tx_q[$], mtx_q[$];
    int          m_ferr = 0, m_ovf = 0, m_und = 0, held = 0, sent = 48;
    bit          rdy_mode = 1, tx_en = 0, tx_pend = 0, last_drx = 0;
    logic [47:0] cur_word = '0;

    always @(negedge clk) begin
        if (rx_tvalid_o && rx_tready_i) got_q.push_back(rx_tdata_o);
        if (tx_tvalid_i && tx_tready_o) tx_pend = 1;
    end

    always @(posedge clk) begin
        logic [47:0] tmp;
        #1;
        if (tx_pend) begin
            if (tx_q.size() > 0) tmp = tx_q.pop_front();
            tx_pend = 0;
        end
        tx_tvalid_i = tx_en && (tx_q.size() > 0);
        tx_tdata_i  = (tx_q.size() > 0) ? tx_q[0] : '0;
    end

    function automatic void model_push(input logic [47:0] w);
        if (rdy_mode) exp_q.push_back(w);
        else if (held < 4) begin
            exp_q.push_back(w);
            held++;
        end else m_ovf++;
    endfunction

    function automatic void model_fall();
        if (enable_i && sent < 48) begin
            last_drx = cur_word[47 - sent];
            sent++;
        end
    endfunction

    function automatic void model_rise(input bit d, input bit s);
        logic [47:0] w, nw;
        bit done;
        w = '0; nw = '0; done = 0;
        if (!enable_i) return;
        if (s) begin
            if (m_frame.size() == 47) begin
                foreach (m_frame[i]) w = {w[46:0], m_frame[i]};
                w = {w[46:0], d};
                done = 1;
                model_push(w);
            end else if (m_frame.size() != 0) m_ferr++;
            m_frame.delete();
            if (loopback_i) nw = done ? w : '0;
            else if (tx_en && mtx_q.size() > 0) nw = mtx_q.pop_front();
            else m_und++;
            cur_word = nw;
            sent = 0;
        end else if (m_frame.size() == 47) begin
            m_ferr++;
            m_frame.delete();
        end else m_frame.push_back(d);
    endfunction

    task automatic send_bit(input bit d, input bit s, output bit smp);
        mck_i = 1'b0; dtx_i = d; dsync_i = s;
        model_fall();
        repeat (4) @(posedge clk);
        #1;
        smp = drx_o;
        check("drx", drx_o, last_drx);
        mck_i = 1'b1;
        model_rise(d, s);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input int n, input bit s);
        bit b;
        for (int i = 0; i < n; i++) send_bit(1'($urandom_range(0, 1)), s, b);
    endtask

    task automatic send_word(input logic [47:0] w, output logic [47:0] cap);
        bit b;
        cap = '0;
        for (int i = 47; i >= 0; i--) begin
            send_bit(w[i], i == 0, b);
            cap = {cap[46:0], b};
        end
    endtask

    task automatic drain_check(input string tag);
        repeat (20) @(posedge clk);
        #1;
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check({tag, "_word"}, got_q[i], exp_q[i]);
        check({tag, "_tvalid"}, rx_tvalid_o, 1'b0);
        got_q.delete(); exp_q.delete(); held = 0;
    endtask

    task automatic do_reset();
        mck_i = 1'b0; dsync_i = 1'b1; dtx_i = 1'b0; rst_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_i = 1'b0;
        m_frame.delete(); exp_q.delete(); got_q.delete();
        m_ferr = 0; m_ovf = 0; m_und = 0; held = 0; sent = 48; last_drx = 0; cur_word = '0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_drx"}, drx_o, 1'b0);
        check({tag, "_rx_tvalid"}, rx_tvalid_o, 1'b0);
        check({tag, "_rx_tdata"}, rx_tdata_o, 48'h0);
        check({tag, "_tx_tready"}, tx_tready_o, 1'b0);
        check({tag, "_ferr"}, frame_err_count_o, 16'h0);
        check({tag, "_ovf"}, overflow_count_o, 16'h0);
        check({tag, "_und"}, underrun_count_o, 16'h0);
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_ferr"}, frame_err_count_o, 64'(m_ferr));
        check({tag, "_ovf"}, overflow_count_o, 64'(m_ovf));
        check({tag, "_und"}, underrun_count_o, 64'(m_und));
    endtask

    initial begin
        logic [47:0] cap, w1, w2;
        int          u0;
        enable_i = 1'b1; loopback_i = 1'b0; rx_tready_i = 1'b1;
        tx_tvalid_i = 1'b0; tx_tdata_i = '0;
        @(posedge clk);
        #1;
        do_reset();
        check_reset_state("reset");

        send_bits(10, 1'b1);
        send_word(48'hA5A5_0F0F_1234, cap);
        drain_check("basic");
        check("basic_ferr", frame_err_count_o, 16'h0);

        send_bits(200, 1'b1);
        send_word({16'($urandom()), $urandom()}, cap);
        send_word({16'($urandom()), $urandom()}, cap);
        check("b2b_n", exp_q.size(), 2);
        drain_check("b2b");
        check_counters("b2b");

        send_bits(19, 1'b0);
        send_bits(1, 1'b1);
        check("short_ferr", frame_err_count_o, 16'h1);
        check("short_nopush", rx_tvalid_o, 1'b0);
        send_word(48'h1357_9BDF_2468, cap);
        drain_check("short");

        rx_tready_i = 1'b0; rdy_mode = 0; held = 0;
        for (int f = 0; f < 6; f++) send_word({16'($urandom()), $urandom()}, cap);
        check("ovf_tvalid", rx_tvalid_o, 1'b1);
        check("ovf_count", overflow_count_o, 16'h2);
        rx_tready_i = 1'b1; rdy_mode = 1;
        drain_check("ovf");

        loopback_i = 1'b1;
        send_word(48'h0000_0000_0001, cap);
        send_word(48'hFFFF_0000_FFFF, cap);
        check("lb_word1", cap, 48'h0000_0000_0001);
        send_word(48'h0F0F_F0F0_3C3C, cap);
        check("lb_word2", cap, 48'hFFFF_0000_FFFF);
        loopback_i = 1'b0; tx_en = 0;
        u0 = m_und;
        send_word(48'h0123_4567_89AB, cap);
        check("lb_last", cap, 48'h0F0F_F0F0_3C3C);
        send_word(48'hFEDC_BA98_7654, cap);
        check("underrun_zero1", cap, 48'h0);
        send_word(48'h5555_AAAA_5555, cap);
        check("underrun_zero2", cap, 48'h0);
        check("underrun_delta", underrun_count_o, 64'(u0 + 3));
        drain_check("lb");

        w1 = {16'($urandom()), $urandom()};
        w2 = {16'($urandom()), $urandom()};
        tx_q.push_back(w1); mtx_q.push_back(w1);
        tx_q.push_back(w2); mtx_q.push_back(w2);
        tx_en = 1;
        send_word({16'($urandom()), $urandom()}, cap);
        send_word({16'($urandom()), $urandom()}, cap);
        check("tx_word1", cap, w1);
        send_word({16'($urandom()), $urandom()}, cap);
        check("tx_word2", cap, w2);
        tx_en = 0;
        drain_check("tx");

        send_bits(10, 1'b0);
        enable_i = 1'b0; m_frame.delete(); sent = 48; last_drx = 0;
        send_bits(6, 1'b0);
        check("dis_drx", drx_o, 1'b0);
        enable_i = 1'b1;
        send_bits(3, 1'b1);
        send_word(48'hC0DE_CAFE_BEEF, cap);
        drain_check("enable");
        check_counters("enable");

        for (int f = 0; f < 40; f++) begin
            loopback_i = ($urandom_range(0, 3) == 0);
            tx_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) begin
                w1 = {16'($urandom()), $urandom()};
                tx_q.push_back(w1); mtx_q.push_back(w1);
            end
            case ($urandom_range(0, 9))
                0: send_bits($urandom_range(1, 4), 1'b1);
                1: begin send_bits($urandom_range(1, 46), 1'b0); send_bits(1, 1'b1); end
                2: begin send_bits($urandom_range(48, 56), 1'b0); send_bits(1, 1'b1); end
                default: send_word({16'($urandom()), $urandom()}, cap);
            endcase
        end
        tx_en = 0; loopback_i = 1'b0;
        drain_check("rand");
        check_counters("rand");
        check("tx_consumed", tx_q.size(), mtx_q.size());

        send_bits(20, 1'b0);
        do_reset();
        check_reset_state("midreset");
        send_word(48'h8000_0000_0001, cap);
        drain_check("postreset");
        check_counters("postreset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
